// File: rtl/knn_feeder_if.sv
// Beat-in / result-out handshake bundle for the kNN feeder.
// The host drives beats and accepts results; the feeder does the rest.
interface knn_feeder_if #(
  parameter int VECT_LEN = 4,
  parameter int WORD_LEN = 6,
  parameter int LBL_LEN  = 10
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_query;
  logic [WORD_LEN-1:0]   s_vec [VECT_LEN];
  logic [LBL_LEN-1:0]    s_lbl;
  logic                  res_valid;
  logic                  res_ready;
  logic [LBL_LEN/2-1:0]  res_x;
  logic [LBL_LEN/2-1:0]  res_y;

  modport master (
    output s_valid, s_query, s_vec, s_lbl, res_ready,
    input  s_ready, res_valid, res_x, res_y
  );

  modport slave (
    input  s_valid, s_query, s_vec, s_lbl, res_ready,
    output s_ready, res_valid, res_x, res_y
  );
endinterface

// File: rtl/knn_feeder.sv
// Host-side loader for the kNN classifier: rotates training vectors
// into slots, strobes query arguments and returns the x/y result.
module knn_feeder #(
  parameter int VECT_NUM = 6,
  parameter int VECT_LEN = 4,
  parameter int WORD_LEN = 6,
  parameter int LBL_LEN  = 10,
  parameter int RES_LAT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  knn_feeder_if.slave          s,
  output logic [VECT_NUM-1:0]  dclk,
  output logic                 enaV,
  output logic [WORD_LEN-1:0]  inV [VECT_LEN],
  output logic [LBL_LEN-1:0]   inL,
  input  logic [LBL_LEN/2-1:0] x_in,
  input  logic [LBL_LEN/2-1:0] y_in,
  output logic                 loaded,
  output logic                 err
);
  localparam int CW = $clog2(RES_LAT + 1);
  localparam int SW = (VECT_NUM > 1) ? $clog2(VECT_NUM) : 1;
  localparam int HL = LBL_LEN / 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [VECT_NUM-1:0] dclk_q, dclk_d;
  logic                enav_q, enav_d;
  logic [WORD_LEN-1:0] inv_q [VECT_LEN];
  logic [WORD_LEN-1:0] inv_d [VECT_LEN];
  logic [LBL_LEN-1:0]  inl_q, inl_d;
  logic                ld_q, ld_d;
  logic                err_q, err_d;
  logic                rv_q, rv_d;
  logic [HL-1:0]       rx_q, rx_d;
  logic [HL-1:0]       ry_q, ry_d;
  logic                rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    dclk_d  = '0;
    enav_d  = 1'b0;
    err_d   = 1'b0;
    inv_d   = inv_q;
    inl_d   = inl_q;
    ld_d    = ld_q;
    rv_d    = rv_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    unique case (state_q)
      IDLE: begin
        if (s.s_valid && rdy_q) begin
          if (!s.s_query) begin
            inv_d  = s.s_vec;
            inl_d  = s.s_lbl;
            dclk_d = VECT_NUM'(1) << slot_q;
            if (slot_q == SW'(VECT_NUM - 1)) begin
              slot_d = '0;
              ld_d   = 1'b1;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else if (!ld_q) begin
            err_d = 1'b1;
          end else begin
            inv_d   = s.s_vec;
            enav_d  = 1'b1;
            cnt_d   = CW'(RES_LAT);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          rx_d    = x_in;
          ry_d    = y_in;
          rv_d    = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESULT: begin
        if (s.res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ready is a registered decode so it reads 0 while in reset
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      dclk_q  <= '0;
      enav_q  <= 1'b0;
      inv_q   <= '{default: '0};
      inl_q   <= '0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      dclk_q  <= dclk_d;
      enav_q  <= enav_d;
      inv_q   <= inv_d;
      inl_q   <= inl_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s.s_ready   = rdy_q;
  assign s.res_valid = rv_q;
  assign s.res_x     = rx_q;
  assign s.res_y     = ry_q;
  assign dclk        = dclk_q;
  assign enaV        = enav_q;
  assign inV         = inv_q;
  assign inL         = inl_q;
  assign loaded      = ld_q;
  assign err         = err_q;
endmodule

// File: tb/tb_knn_feeder.sv
// Directed bench for knn_feeder: vector table for loading,
// hand sequences for query latency, backpressure and reset.
module tb_knn_feeder;
  localparam int RES_LAT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] dclk;
  logic       enaV;
  logic [5:0] inV [4];
  logic [9:0] inL;
  logic [4:0] x_in, y_in;
  logic       loaded, err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  knn_feeder_if #(.VECT_LEN(4), .WORD_LEN(6), .LBL_LEN(10)) bus ();

  knn_feeder #(
    .VECT_NUM(6), .VECT_LEN(4), .WORD_LEN(6),
    .LBL_LEN(10), .RES_LAT(RES_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .dclk(dclk), .enaV(enaV), .inV(inV), .inL(inL),
    .x_in(x_in), .y_in(y_in), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v, q;
    logic [9:0]      lbl;
    logic [3:0][5:0] vec;
    logic            e_rdy;
    logic [5:0]      e_dclk;
    logic            e_ena;
    logic [9:0]      e_inl;
    logic [3:0][5:0] e_vec;
    logic            e_ld, e_err;
  } row_t;

  row_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic logic [23:0] cur_inv();
    logic [3:0][5:0] p;
    for (int w = 0; w < 4; w++) p[w] = inV[w];
    return p;
  endfunction

  function automatic row_t mk(logic v, logic q, logic [9:0] lbl,
                              logic [3:0][5:0] vec, logic e_rdy,
                              logic [5:0] e_dclk, logic e_ena,
                              logic [9:0] e_inl, logic [3:0][5:0] e_vec,
                              logic e_ld, logic e_err);
    row_t r;
    r.v = v; r.q = q; r.lbl = lbl; r.vec = vec; r.e_rdy = e_rdy;
    r.e_dclk = e_dclk; r.e_ena = e_ena; r.e_inl = e_inl;
    r.e_vec = e_vec; r.e_ld = e_ld; r.e_err = e_err;
    return r;
  endfunction

  task automatic drive(input logic v, input logic q, input logic [9:0] l,
                       input logic [3:0][5:0] vec);
    bus.s_valid = v;
    bus.s_query = q;
    bus.s_lbl   = l;
    for (int w = 0; w < 4; w++) bus.s_vec[w] = vec[w];
  endtask

  initial begin
    logic [3:0][5:0] tv, qv, last;
    logic seen;
    drive(1'b0, 1'b0, '0, '0);
    bus.res_ready = 1'b0;
    x_in = '0;
    y_in = '0;

    // table: early query, six back-to-back loads, wrap, idle
    tbl[0] = mk(1, 1, 10'h155, {6'd9, 6'd9, 6'd9, 6'd9},
                1, 6'b0, 0, 10'h0, '0, 0, 1);
    tbl[1] = mk(0, 0, 10'h0, '0, 1, 6'b0, 0, 10'h0, '0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 4; w++) tv[w] = 6'(i * 4 + w + 1);
      tbl[2+i] = mk(1, 0, 10'(10'h041 + i), tv, 1, 6'(1 << i), 0,
                    10'(10'h041 + i), tv, (i == 5), 0);
    end
    last = {6'd60, 6'd61, 6'd62, 6'd63};
    tbl[8] = mk(1, 0, 10'h3FF, last, 1, 6'b000001, 0, 10'h3FF, last, 1, 0);
    tbl[9] = mk(0, 0, 10'h0, '0, 1, 6'b0, 0, 10'h3FF, last, 1, 0);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_dclk", dclk, 0);
    chk("rst_enaV", enaV, 0);
    chk("rst_inV", cur_inv(), 0);
    chk("rst_inL", inL, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_err", err, 0);
    chk("rst_res", {bus.res_valid, bus.res_x, bus.res_y}, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", bus.s_ready, 1);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].q, tbl[i].lbl, tbl[i].vec);
      @(negedge clk);
      chk($sformatf("r%0d_rdy", i), bus.s_ready, tbl[i].e_rdy);
      chk($sformatf("r%0d_dclk", i), dclk, tbl[i].e_dclk);
      chk($sformatf("r%0d_enaV", i), enaV, tbl[i].e_ena);
      chk($sformatf("r%0d_inL", i), inL, tbl[i].e_inl);
      chk($sformatf("r%0d_inV", i), cur_inv(), tbl[i].e_vec);
      chk($sformatf("r%0d_loaded", i), loaded, tbl[i].e_ld);
      chk($sformatf("r%0d_err", i), err, tbl[i].e_err);
    end

    // query with RES_LAT latency
    qv = {6'd4, 6'd3, 6'd2, 6'd1};
    x_in = 5'd5;
    y_in = 5'd17;
    drive(1, 1, 10'h2AA, qv);
    @(negedge clk);
    drive(0, 0, '0, '0);
    chk("q_enaV", enaV, 1);
    chk("q_dclk", dclk, 0);
    chk("q_inV", cur_inv(), qv);
    chk("q_inL", inL, 10'h3FF);
    chk("q_rdy", bus.s_ready, 0);
    for (int k = 1; k < RES_LAT; k++) begin
      @(negedge clk);
      chk($sformatf("w%0d", k), {bus.res_valid, bus.s_ready, enaV}, 0);
    end
    @(negedge clk);
    chk("q_valid", bus.res_valid, 1);
    chk("q_x", bus.res_x, 5);
    chk("q_y", bus.res_y, 17);

    // backpressure: result must stay frozen
    for (int k = 0; k < 10; k++) begin
      x_in = 5'(k * 3 + 1);
      y_in = 5'(~k);
      @(negedge clk);
      chk($sformatf("bp%0d", k),
          {bus.res_valid, bus.s_ready, bus.res_x, bus.res_y},
          {1'b1, 1'b0, 5'd5, 5'd17});
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("acc_valid", bus.res_valid, 0);
    chk("acc_rdy", bus.s_ready, 1);

    // reset in WAIT drops the pending result and the loaded flag
    drive(1, 1, '0, qv);
    @(negedge clk);
    drive(0, 0, '0, '0);
    chk("q2_enaV", enaV, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_loaded", loaded, 0);
    chk("mid_rdy", bus.s_ready, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (RES_LAT + 2) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("no_result", seen, 0);
    chk("post_loaded", loaded, 0);
    drive(1, 1, '0, qv);
    @(negedge clk);
    drive(0, 0, '0, '0);
    chk("post_err", {err, enaV}, 2'b10);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/knn_feeder.md
Name: knn_feeder

Overview:
- Host-side driver for the kNN classifier's load/argument interface. It generates the classifier's dclk, enaV, inV and inL inputs, and it collects the classifier's x and y outputs.
- Accepts a valid/ready stream of beats. Each beat is either a labelled training vector or a query argument.
- Training beats are written into the classifier's vector slots in rotation.
- For a query beat, the block strobes the argument in, waits a fixed pipeline latency, samples the classifier's coordinates, and returns them through a valid/ready result handshake.

Parameters:
VECT_NUM, 6, number of training-vector slots (width of dclk)
VECT_LEN, 4, words per vector
WORD_LEN, 6, bits per vector word
LBL_LEN, 10, label width; coordinates are LBL_LEN/2 bits each
RES_LAT, 16, cycles from the enaV pulse to a valid x/y at the classifier output (must be >= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_query  in  1  1 = query argument, 0 = training vector
s_vec  in  WORD_LEN x [VECT_LEN]  vector words (unpacked array, index 0..VECT_LEN-1)
s_lbl  in  LBL_LEN  training label (ignored for query beats)
dclk  out  VECT_NUM  one-hot slot-write strobe to the classifier
enaV  out  1  argument-write strobe to the classifier
inV  out  WORD_LEN x [VECT_LEN]  vector to the classifier
inL  out  LBL_LEN  label to the classifier
x_in  in  LBL_LEN/2  classifier x result
y_in  in  LBL_LEN/2  classifier y result
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_x  out  LBL_LEN/2  captured x
res_y  out  LBL_LEN/2  captured y
loaded  out  1  all VECT_NUM slots have been written since reset
err  out  1  one-cycle pulse: a query was dropped because loaded=0

Behaviour:
- Reset values (asynchronous): every output register is 0, including dclk, enaV, inV, inL, res_valid, res_x, res_y, loaded and err. Slot pointer = 0. State = IDLE.
- Acceptance: a beat is accepted when s_valid && s_ready at a rising edge. s_ready = (state == IDLE). s_ready is a function of state only, never of s_valid or s_query.
- FSM states: IDLE, WAIT, RESULT.
- IDLE, training beat accepted at edge N:
  - At edge N, inV <= s_vec, inL <= s_lbl, and dclk <= one-hot(slot).
  - dclk is high for exactly the cycle following edge N.
  - slot increments; after VECT_NUM-1 it wraps to 0.
  - loaded is set when slot wraps to 0 and stays set (sticky) until reset.
  - State remains IDLE, so back-to-back training beats at one per cycle are legal.
  - After the 7th beat with default parameters, slot 0 is overwritten with the new vector and label.
- IDLE, query beat accepted with loaded=0:
  - The beat is consumed and discarded.
  - err pulses for one cycle; no other output changes.
- IDLE, query beat accepted with loaded=1:
  - At edge N, inV <= s_vec; inL is unchanged.
  - enaV is high for exactly the cycle following edge N.
  - Counter is loaded with RES_LAT; state moves to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - At edge N+RES_LAT, res_x <= x_in, res_y <= y_in, res_valid <= 1, and state moves to RESULT.
- RESULT:
  - res_valid, res_x and res_y hold until res_valid && res_ready at an edge.
  - At that edge, res_valid <= 0 and state moves to IDLE; s_ready is high in the following cycle.
  - A result is never lost and never overwritten.
- Hold behaviour:
  - inV and inL hold between accepted beats.
  - dclk and enaV are 0 whenever no strobe is in progress.
  - dclk and enaV are never asserted in the same cycle.
- Reset asserted mid-operation (any state): immediate return to reset values.
  - loaded is cleared; all slots are treated as empty.
  - A pending result is discarded.
- All outputs are registered; there are no combinational paths from input to output except s_ready, which is decoded from state only.

Test Plan:
- Reset check: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, including s_ready=0 during reset; s_ready=1 after release.
- Back-to-back load: 6 training beats on consecutive cycles with labels 0x041..0x046 -> dclk = 000001, 000010, ... 100000 on consecutive cycles, with inL matching each beat. loaded rises together with the 6th strobe.
- Slot wrap: 7th training beat with label 0x3FF -> dclk = 000001, inL = 0x3FF, loaded stays 1.
- Early query: query beat before the 6th training beat -> err=1 for one cycle, enaV stays 0, state stays IDLE.
- Query result: after load, query with s_vec = {1,2,3,4}, x_in = 5, y_in = 17 driven -> enaV=1 for one cycle with inV = {1,2,3,4}. res_valid rises exactly RES_LAT edges later with res_x=5, res_y=17. s_ready=0 throughout.
- Backpressure and reset: hold res_ready=0 for 10 cycles while toggling x_in -> res_x/res_y stay frozen and res_valid stays high. Pulse rst_n=0 during a WAIT -> no res_valid appears, and loaded=0.
